// File: rtl/sort_pkg.sv
// Shared types for the sorter stream controller.
package sort_pkg;

  typedef enum logic [1:0] {FILL, LOAD, SORT, DRAIN} sort_state_t;

  localparam int SORT_W = 32;

  typedef logic [SORT_W-1:0] sort_word_t;

endpackage

// File: rtl/sort_stream_ctrl.sv
// Streaming front/back end for the odd-even transposition sorter.
// A frame of N words is collected in ibuf, parallel-loaded into the sorter,
// left to run N phases, then captured into obuf and streamed out in index order.
//
// Handshakes: a word moves on a rising edge where valid && ready are both
// high; valid never waits on ready, and data/last stay stable while valid is
// high and ready is low.
module sort_stream_ctrl
  import sort_pkg::*;
#(
  parameter int N = 8,
  parameter int W = SORT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_data,
  output logic            srt_load,
  output logic [N*W-1:0]  srt_in_flat,
  input  logic [N*W-1:0]  srt_out_flat,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_data,
  output logic            m_last,
  output logic            busy,
  output sort_state_t     state_dbg
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N);

  sort_state_t    state_q, state_d;
  logic [IW-1:0]  widx_q, widx_d;
  logic [IW-1:0]  ridx_q, ridx_d;
  logic [PW-1:0]  phase_cnt_q, phase_cnt_d;
  logic [N*W-1:0] ibuf_q, ibuf_d;
  logic [N*W-1:0] obuf_q, obuf_d;

  // Next-state logic: frame collection, sort phase counting, and drain indexing.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    ridx_d      = ridx_q;
    phase_cnt_d = phase_cnt_q;
    ibuf_d      = ibuf_q;
    obuf_d      = obuf_q;
    case (state_q)
      FILL: begin
        if (s_valid) begin
          ibuf_d[int'(widx_q)*W +: W] = s_data;
          if (widx_q == LAST_IDX) begin
            widx_d  = '0;
            state_d = LOAD;
          end else begin
            widx_d = widx_q + IW'(1);
          end
        end
      end
      LOAD: begin
        state_d = SORT;
      end
      SORT: begin
        // The sorter has completed N phases once the count reaches N; the
        // snapshot is taken only here so later sorter activity is ignored.
        if (phase_cnt_q == LAST_PHASE) begin
          obuf_d      = srt_out_flat;
          phase_cnt_d = '0;
          state_d     = DRAIN;
        end else begin
          phase_cnt_d = phase_cnt_q + PW'(1);
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (ridx_q == LAST_IDX) begin
            ridx_d  = '0;
            state_d = FILL;
          end else begin
            ridx_d = ridx_q + IW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      widx_q      <= '0;
      ridx_q      <= '0;
      phase_cnt_q <= '0;
      ibuf_q      <= '0;
      obuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      ridx_q      <= ridx_d;
      phase_cnt_q <= phase_cnt_d;
      ibuf_q      <= ibuf_d;
      obuf_q      <= obuf_d;
    end
  end

  // Control outputs are pure decodes of the registered state.
  always_comb begin
    s_ready     = (state_q == FILL);
    srt_load    = (state_q == LOAD);
    m_valid     = (state_q == DRAIN);
    m_last      = (state_q == DRAIN) && (ridx_q == LAST_IDX);
    busy        = (state_q != FILL);
    m_data      = (state_q == DRAIN) ? obuf_q[int'(ridx_q)*W +: W] : '0;
    srt_in_flat = ibuf_q;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl: sibling sorter model, frame driver, and a
// scoreboard fed with sorted expectations.
module tb_sort_stream_ctrl;
  import sort_pkg::*;

  localparam int N = 8;
  localparam int W = 32;

  typedef logic [W-1:0] frame_t [N];

  logic           clk;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic           srt_load;
  logic [N*W-1:0] srt_in_flat;
  logic [N*W-1:0] srt_out_flat;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic           m_last;
  logic           busy;
  sort_state_t    state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit bp_mode = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] in_words[$];
  int last_in_cyc  = 0;
  int last_out_cyc = 0;

  sort_stream_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .srt_load(srt_load), .srt_in_flat(srt_in_flat), .srt_out_flat(srt_out_flat),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- sorter model (sibling) ----------------
  function automatic logic [N*W-1:0] do_phase(input logic [N*W-1:0] a, input bit odd);
    logic [N*W-1:0] r;
    r = a;
    for (int i = (odd ? 1 : 0); i + 1 < N; i += 2) begin
      if (a[i*W +: W] > a[(i+1)*W +: W]) begin
        r[i*W +: W]     = a[(i+1)*W +: W];
        r[(i+1)*W +: W] = a[i*W +: W];
      end
    end
    return r;
  endfunction

  logic [N*W-1:0] srt_arr;
  bit             srt_odd;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      srt_arr <= '0;
      srt_odd <= 1'b0;
    end else if (srt_load) begin
      srt_arr <= srt_in_flat;
      srt_odd <= 1'b0;
    end else begin
      srt_arr <= do_phase(srt_arr, srt_odd);
      srt_odd <= ~srt_odd;
    end
  end
  assign srt_out_flat = srt_arr;

  // ---------------- helpers ----------------
  function automatic frame_t sorted(input frame_t d);
    logic [W-1:0] q[$];
    frame_t r;
    for (int i = 0; i < N; i++) q.push_back(d[i]);
    q.sort();
    for (int i = 0; i < N; i++) r[i] = q[i];
    return r;
  endfunction

  function automatic logic [N*W-1:0] pack(input frame_t d);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = d[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input frame_t d, input frame_t e, input bit gaps, output int first_cyc);
    int to;
    first_cyc = -1;
    for (int i = 0; i < N; i++) exp_q.push_back(e[i]);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      s_valid = 1'b1;
      s_data  = d[i];
      to = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        to++;
        if (to > 200) break;
      end
      if (to > 200) begin
        tests++;
        fails++;
        $display("FAIL input_timeout: word %0d not accepted within 200 cycles", i);
        s_valid = 1'b0;
        return;
      end
      if (i == 0) first_cyc = cyc;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int to;
    to = 0;
    while (exp_q.size() > 0 && to < 500) begin
      @(posedge clk);
      to++;
    end
    #1;
    tests++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // m_ready driver: steady high, or the 1,0,0 backpressure pattern
  initial begin
    int k;
    k = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) m_ready = ((k % 3) == 0);
      else         m_ready = 1'b1;
      k++;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  initial begin
    int out_pos;
    bit prev_stall;
    bit prev_load;
    bit first_pending;
    logic [W-1:0] prev_data;
    logic         prev_last;
    logic [N*W-1:0] exp_load;
    out_pos = 0; prev_stall = 0; prev_load = 0; first_pending = 0;
    prev_data = '0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_pos = 0; prev_stall = 0; prev_load = 0; first_pending = 0;
        in_words.delete();
      end else begin
        check("busy_decode", busy, !s_ready);
        if (s_valid && s_ready) begin
          in_words.push_back(s_data);
          last_in_cyc = cyc;
        end
        if (srt_load) begin
          check("load_pulse_width", prev_load, 1'b0);
          check("load_s_ready", s_ready, 1'b0);
          check("load_word_count", in_words.size(), N);
          exp_load = '0;
          for (int i = 0; i < N && i < in_words.size(); i++) exp_load[i*W +: W] = in_words[i];
          check("srt_in_flat", srt_in_flat, exp_load);
          in_words.delete();
          first_pending = 1;
        end
        prev_load = srt_load;
        if (m_valid) begin
          check("drain_s_ready", s_ready, 1'b0);
          if (first_pending) begin
            check("first_out_latency", cyc - last_in_cyc, 11);
            first_pending = 0;
          end
          if (prev_stall) begin
            check("hold_data", m_data, prev_data);
            check("hold_last", m_last, prev_last);
          end
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %0h with nothing expected", m_data);
          end else begin
            check("m_data", m_data, exp_q[0]);
            check("m_last", m_last, out_pos == N - 1);
            if (m_ready) begin
              void'(exp_q.pop_front());
              if (m_last) last_out_cyc = cyc;
              out_pos = (out_pos + 1) % N;
            end
          end
          prev_stall = !m_ready;
          prev_data  = m_data;
          prev_last  = m_last;
        end else begin
          check("m_last_idle", m_last, 1'b0);
          prev_stall = 0;
        end
      end
    end
  end

  // ---------------- directed test sequence ----------------
  initial begin
    frame_t f_basic, e_basic, f_ext, e_ext, f_rev, e_rev, f_a, f_b;
    int fc, fc_b;

    f_basic = '{32'd5, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
    e_basic = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    f_ext   = '{32'hFFFFFFFF, 32'h0, 32'd7, 32'd7, 32'h80000000, 32'd1, 32'd7, 32'h0};
    e_ext   = '{32'h0, 32'h0, 32'd1, 32'd7, 32'd7, 32'd7, 32'h80000000, 32'hFFFFFFFF};
    f_rev   = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    f_a     = '{32'd40, 32'd10, 32'd30, 32'd20, 32'd80, 32'd60, 32'd70, 32'd50};
    f_b     = '{32'd3, 32'd1000, 32'd2, 32'd999, 32'd1, 32'd500, 32'd0, 32'd4};

    // pin the reference model against hand-sorted frames
    check("model_pin_basic", pack(sorted(f_basic)), pack(e_basic));
    check("model_pin_ext", pack(sorted(f_ext)), pack(e_ext));
    e_rev = sorted(f_rev);

    // reset asserted between edges
    s_valid = 1'b0;
    s_data  = '0;
    rst     = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_srt_load", srt_load, 1'b0);
    check("rst_srt_in_flat", srt_in_flat, '0);
    check("rst_m_data", m_data, '0);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // basic frame, m_ready steady high
    send_frame(f_basic, e_basic, 1'b0, fc);
    wait_drain();

    // backpressure 1,0,0 pattern
    bp_mode = 1;
    send_frame(f_basic, e_basic, 1'b0, fc);
    wait_drain();
    bp_mode = 0;

    // input gaps, duplicates and extremes
    send_frame(f_ext, e_ext, 1'b1, fc);
    wait_drain();

    // reset mid-SORT at phase_cnt==3
    send_frame(f_basic, e_basic, 1'b0, fc);
    repeat (4) @(posedge clk);
    #1;
    check("mid_sort_state", state_dbg, SORT);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_s_ready", s_ready, 1'b1);
    check("abort_m_valid", m_valid, 1'b0);
    check("abort_srt_in_flat", srt_in_flat, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // full frame after the aborted one
    send_frame(f_rev, e_rev, 1'b0, fc);
    wait_drain();

    // back-to-back frames A then B
    send_frame(f_a, sorted(f_a), 1'b0, fc);
    send_frame(f_b, sorted(f_b), 1'b0, fc_b);
    check("b2b_first_accept", fc_b, last_out_cyc + 1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
